// File: rtl/uc_fsm.sv
// uc_fsm -- control unit for the microc datapath.
//
// Decodes Opcode and the registered zero flag into the control word that
// microc consumes. The decode is purely combinational. A RUN/HALT/ERROR state
// machine, a consecutive-J loop detector and a retired-instruction counter sit
// on top of the decode.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   Opcode      in   [5:0] instruction opcode from microc
//   zero        in   registered zero flag from microc
//   s_inc       out  1 = PC+1, 0 = load jump target
//   s_inm       out  1 = immediate operand on register file write path
//   we          out  register file write enable
//   wez         out  zero flag write enable
//   ALUOp       out  [2:0] ALU operation
//   halted      out  sticky, jump-loop halt detected
//   error       out  sticky, illegal opcode executed
//   instr_count out  [CNT_W-1:0] instructions retired since reset
module uc_fsm #(
    parameter int HALT_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    localparam int JW = $clog2(HALT_THRESH) + 1;
    localparam logic [JW-1:0] JLAST = JW'(HALT_THRESH - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [JW-1:0]    jcnt_q, jcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             legal;
    logic             is_j;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            jcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            jcnt_q  <= jcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we      = 1'b0;
        wez     = 1'b0;
        ALUOp   = 3'b000;
        state_d = state_q;
        jcnt_d  = jcnt_q;
        cnt_d   = cnt_q;
        legal   = 1'b1;
        is_j    = 1'b0;

        // While in reset the control word stays at its idle defaults.
        if (!reset) begin
            unique case (state_q)
                S_RUN: begin
                    case (Opcode[5:3])
                        3'b000: begin
                            ALUOp = Opcode[2:0];
                            we    = 1'b1;
                            wez   = 1'b1;
                        end
                        3'b001: begin
                            ALUOp = Opcode[2:0];
                            s_inm = 1'b1;
                            we    = 1'b1;
                            wez   = 1'b1;
                        end
                        3'b010: begin
                            case (Opcode[2:0])
                                3'b000: begin
                                    s_inc = 1'b0;
                                    is_j  = 1'b1;
                                end
                                3'b001:  s_inc = ~zero;
                                3'b010:  s_inc = zero;
                                default: legal = 1'b0;
                            endcase
                        end
                        3'b011: legal = (Opcode[2:0] == 3'b000);
                        default: legal = 1'b0;
                    endcase

                    if (legal) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = S_ERROR;
                    end

                    // Only an unbroken run of J cycles advances the detector.
                    if (is_j) begin
                        if (jcnt_q == JLAST) begin
                            state_d = S_HALT;
                            jcnt_d  = '0;
                        end else begin
                            jcnt_d = jcnt_q + JW'(1);
                        end
                    end else begin
                        jcnt_d = '0;
                    end
                end
                S_HALT: begin
                    s_inc = 1'b0;
                end
                S_ERROR: begin
                    s_inc = 1'b1;
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

    assign halted      = (state_q == S_HALT);
    assign error       = (state_q == S_ERROR);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_uc_fsm.sv
module tb_uc_fsm;

    logic        clk;
    logic        reset;
    logic [5:0]  Opcode;
    logic        zero;
    logic        s_inc, s_inm, we, wez;
    logic [2:0]  ALUOp;
    logic        halted, error;
    logic [15:0] instr_count;

    uc_fsm #(.HALT_THRESH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero),
        .s_inc(s_inc), .s_inm(s_inm), .we(we), .wez(wez), .ALUOp(ALUOp),
        .halted(halted), .error(error), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        s_inc;
        logic        s_inm;
        logic        we;
        logic        wez;
        logic [2:0]  alu;
        logic        halted;
        logic        error;
        logic [15:0] cnt;
    } exp_t;

    exp_t  expq[$];
    string nameq[$];
    int    checks   = 0;
    int    failures = 0;

    localparam logic [5:0] ADD = 6'b000010;
    localparam logic [5:0] LI  = 6'b001000;
    localparam logic [5:0] SBI = 6'b001011;
    localparam logic [5:0] J   = 6'b010000;
    localparam logic [5:0] JZ  = 6'b010001;
    localparam logic [5:0] JNZ = 6'b010010;
    localparam logic [5:0] NOP = 6'b011000;
    localparam logic [5:0] ILL = 6'b100000;

    // Drive one cycle of stimulus and queue what the DUT must show that cycle.
    task automatic step(input string nm, input logic rst, input logic [5:0] op,
                        input logic z, input logic chk,
                        input logic si, input logic sm, input logic w,
                        input logic wz, input logic [2:0] a,
                        input logic h, input logic e, input logic [15:0] c);
        exp_t x;
        @(posedge clk);
        #1;
        reset  = rst;
        Opcode = op;
        zero   = z;
        if (chk) begin
            x.s_inc = si; x.s_inm = sm; x.we = w; x.wez = wz; x.alu = a;
            x.halted = h; x.error = e; x.cnt = c;
            expq.push_back(x);
            nameq.push_back(nm);
        end
    endtask

    // Monitor: the control word is valid every cycle, so pop one expectation
    // per cycle at the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t  x;
        exp_t  act;
        string nm;
        if (expq.size() > 0) begin
            x  = expq.pop_front();
            nm = nameq.pop_front();
            act.s_inc = s_inc; act.s_inm = s_inm; act.we = we; act.wez = wez;
            act.alu = ALUOp; act.halted = halted; act.error = error;
            act.cnt = instr_count;
            checks++;
            if (act !== x) begin
                failures++;
                $display("FAIL %s: got s_inc=%b s_inm=%b we=%b wez=%b alu=%b halted=%b error=%b cnt=%0d ; want s_inc=%b s_inm=%b we=%b wez=%b alu=%b halted=%b error=%b cnt=%0d",
                         nm, act.s_inc, act.s_inm, act.we, act.wez, act.alu,
                         act.halted, act.error, act.cnt, x.s_inc, x.s_inm,
                         x.we, x.wez, x.alu, x.halted, x.error, x.cnt);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        Opcode = ADD;
        zero   = 1'b0;

        // 1. reset, then ADD x3
        step("rst0",   1, ADD, 0, 0, 1,0,0,0,3'b000, 0,0,16'd0);
        step("rst1",   1, ADD, 0, 1, 1,0,0,0,3'b000, 0,0,16'd0);
        step("add0",   0, ADD, 0, 1, 1,0,1,1,3'b010, 0,0,16'd0);
        step("add1",   0, ADD, 0, 1, 1,0,1,1,3'b010, 0,0,16'd1);
        step("add2",   0, ADD, 0, 1, 1,0,1,1,3'b010, 0,0,16'd2);
        // 2. immediates
        step("li",     0, LI,  0, 1, 1,1,1,1,3'b000, 0,0,16'd3);
        step("sbi",    0, SBI, 0, 1, 1,1,1,1,3'b011, 0,0,16'd4);
        // 3. conditional jumps
        step("jz_z1",  0, JZ,  1, 1, 0,0,0,0,3'b000, 0,0,16'd5);
        step("jz_z0",  0, JZ,  0, 1, 1,0,0,0,3'b000, 0,0,16'd6);
        step("jnz_z1", 0, JNZ, 1, 1, 1,0,0,0,3'b000, 0,0,16'd7);
        step("jnz_z0", 0, JNZ, 0, 1, 0,0,0,0,3'b000, 0,0,16'd8);
        // 4. halt loop from a fresh reset
        step("rst_b",  1, ADD, 0, 1, 1,0,0,0,3'b000, 0,0,16'd9);
        step("j1",     0, J,   0, 1, 0,0,0,0,3'b000, 0,0,16'd0);
        step("j2",     0, J,   0, 1, 0,0,0,0,3'b000, 0,0,16'd1);
        step("j3",     0, J,   0, 1, 0,0,0,0,3'b000, 0,0,16'd2);
        step("j4",     0, J,   0, 1, 0,0,0,0,3'b000, 0,0,16'd3);
        step("j5",     0, J,   0, 1, 0,0,0,0,3'b000, 1,0,16'd4);
        step("j6",     0, J,   0, 1, 0,0,0,0,3'b000, 1,0,16'd4);
        step("halt_il",0, ILL, 0, 1, 0,0,0,0,3'b000, 1,0,16'd4);
        step("halt_ad",0, ADD, 0, 1, 0,0,0,0,3'b000, 1,0,16'd4);
        step("rst_h",  1, ADD, 0, 1, 1,0,0,0,3'b000, 1,0,16'd4);
        step("post_h", 0, NOP, 0, 1, 1,0,0,0,3'b000, 0,0,16'd0);
        // 5. non-consecutive J must not halt
        step("jj_a",   0, J,   0, 1, 0,0,0,0,3'b000, 0,0,16'd1);
        step("jj_b",   0, J,   0, 1, 0,0,0,0,3'b000, 0,0,16'd2);
        step("jj_add", 0, ADD, 0, 1, 1,0,1,1,3'b010, 0,0,16'd3);
        step("jj_c",   0, J,   0, 1, 0,0,0,0,3'b000, 0,0,16'd4);
        step("jj_d",   0, J,   0, 1, 0,0,0,0,3'b000, 0,0,16'd5);
        step("jj_e",   0, J,   0, 1, 0,0,0,0,3'b000, 0,0,16'd6);
        step("jj_nop", 0, NOP, 0, 1, 1,0,0,0,3'b000, 0,0,16'd7);
        // 6. illegal opcode and the error state
        step("ill",    0, ILL, 0, 1, 1,0,0,0,3'b000, 0,0,16'd8);
        step("err_add",0, ADD, 0, 1, 1,0,0,0,3'b000, 0,1,16'd8);
        step("err_j",  0, J,   0, 1, 1,0,0,0,3'b000, 0,1,16'd8);
        step("rst_e",  1, ADD, 0, 1, 1,0,0,0,3'b000, 0,1,16'd8);
        step("post_e", 0, ADD, 0, 1, 1,0,1,1,3'b010, 0,0,16'd0);
        step("ill2",   0, 6'b010011, 0, 1, 1,0,0,0,3'b000, 0,0,16'd1);
        step("err2",   0, NOP, 0, 1, 1,0,0,0,3'b000, 0,1,16'd1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        if (expq.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
